spi_norflash_responder: RTL

- Synthesizable device-side SPI NOR flash model: the responder at the far end of the controller's s_mosi/s_miso/s_clk/s_css link.
- Used as the bench target for the APB-to-SPI NOR flash controller and as an FPGA stand-in for a real flash.
- Oversamples the SPI pins in the p_clk domain and implements SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Supported commands: WREN, WRDI, RDSR, READ, PAGE PROGRAM, CHIP ERASE, over a small internal byte array.

---
 rtl/spi_norflash_responder.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_norflash_responder.sv
// Device-side SPI NOR flash model (mode 0, MSB first). The SPI pins are oversampled in the p_clk domain.
// Supports WREN, WRDI, RDSR, READ, PAGE PROGRAM and CHIP ERASE over a small internal byte array.
module spi_norflash_responder #(
    parameter int ADDR_W      = 10,
    parameter int PAGE_W      = 8,
    parameter int PROG_CYCLES = 64
) (
    input  logic p_clk,
    input  logic p_reset,
    input  logic s_clk,
    input  logic s_css,
    input  logic s_mosi,
    output logic s_miso,
    output logic s_miso_oe,
    output logic busy
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_PP_DATA = 3'd4;
    localparam logic [2:0] ST_RDSR    = 3'd5;
    localparam logic [2:0] ST_IGNORE  = 3'd6;

    localparam logic [1:0] ACT_NONE = 2'd0;
    localparam logic [1:0] ACT_WREN = 2'd1;
    localparam logic [1:0] ACT_WRDI = 2'd2;
    localparam logic [1:0] ACT_CE   = 2'd3;

    localparam int PCW = $clog2(PROG_CYCLES + 1);

    // Pin order {s_clk, s_css, s_mosi}; chip select idles high.
    logic [2:0] pin_meta_reg, pin_sync_reg;
    logic       sclk_d_reg, css_d_reg;

    logic [2:0]        state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [6:0]        sr_reg;
    logic [6:0]        tx_reg;
    logic [1:0]        act_reg;
    logic              cmd_exact_reg;
    logic              prog_reg;
    logic              pp_bytes_reg;
    logic [1:0]        addr_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              wel_reg, wip_reg;
    logic [PCW-1:0]    prog_cnt_reg;
    logic              erasing_reg;
    logic [ADDR_W-1:0] erase_ptr_reg;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] mem_q;

    logic        sclk_s, css_s, mosi_s;
    logic        clk_rise, clk_fall, css_rise, css_fall;
    logic        in_frame, byte_done, pp_write, cmd_done;
    logic [7:0]  rx_byte, tx_byte;
    logic [1:0]  act_dec, act_now;
    logic [2:0]  state_dec;
    logic        prog_dec, exact_now, pp_any_now;
    logic [PAGE_W-1:0] page_off_inc;
    logic        mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [7:0]  mem_wd;

    assign sclk_s   = pin_sync_reg[2];
    assign css_s    = pin_sync_reg[1];
    assign mosi_s   = pin_sync_reg[0];
    assign clk_rise = sclk_s & ~sclk_d_reg;
    assign clk_fall = ~sclk_s & sclk_d_reg;
    assign css_rise = css_s & ~css_d_reg;
    assign css_fall = ~css_s & css_d_reg;

    assign in_frame  = (state_reg != ST_IDLE);
    assign rx_byte   = {sr_reg, mosi_s};
    assign byte_done = in_frame && clk_rise && (bit_cnt_reg == 3'd7);
    assign cmd_done  = (state_reg == ST_CMD) && byte_done;
    assign pp_write  = (state_reg == ST_PP_DATA) && byte_done;

    // A byte completing in the same cycle as CS rise still counts for the end-of-frame actions.
    assign exact_now  = cmd_done ? 1'b1 : (cmd_exact_reg && !clk_rise);
    assign act_now    = cmd_done ? act_dec : act_reg;
    assign pp_any_now = pp_bytes_reg | pp_write;

    assign tx_byte      = (state_reg == ST_RDSR) ? {6'b0, wel_reg, wip_reg} : mem_q;
    assign page_off_inc = addr_reg[PAGE_W-1:0] + PAGE_W'(1);
    assign busy         = wip_reg;

    assign mem_we = erasing_reg | pp_write;
    assign mem_wa = erasing_reg ? erase_ptr_reg : addr_reg;
    assign mem_wd = erasing_reg ? 8'hFF : (mem_q & rx_byte);

    always_comb begin
        act_dec   = ACT_NONE;
        state_dec = ST_IGNORE;
        prog_dec  = 1'b0;
        case (rx_byte)
            8'h06: act_dec = ACT_WREN;
            8'h04: act_dec = ACT_WRDI;
            8'h05: state_dec = ST_RDSR;
            8'h03: state_dec = ST_ADDR;
            8'h02: if (wel_reg) begin
                state_dec = ST_ADDR;
                prog_dec  = 1'b1;
            end
            8'hC7: if (wel_reg) act_dec = ACT_CE;
            default: ;
        endcase
        if (wip_reg && rx_byte != 8'h05) begin
            act_dec   = ACT_NONE;
            state_dec = ST_IGNORE;
            prog_dec  = 1'b0;
        end
    end

    // Array is not reset so it maps onto block RAM; mem_q is stable well before any byte completes.
    always_ff @(posedge p_clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
        mem_q <= mem[addr_reg];
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            pin_meta_reg  <= 3'b010;
            pin_sync_reg  <= 3'b010;
            sclk_d_reg    <= 1'b0;
            css_d_reg     <= 1'b1;
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            sr_reg        <= 7'd0;
            tx_reg        <= 7'd0;
            act_reg       <= ACT_NONE;
            cmd_exact_reg <= 1'b0;
            prog_reg      <= 1'b0;
            pp_bytes_reg  <= 1'b0;
            addr_cnt_reg  <= 2'd0;
            addr_reg      <= '0;
            wel_reg       <= 1'b0;
            wip_reg       <= 1'b0;
            prog_cnt_reg  <= '0;
            erasing_reg   <= 1'b0;
            erase_ptr_reg <= '0;
            s_miso        <= 1'b0;
            s_miso_oe     <= 1'b0;
        end else begin
            pin_meta_reg <= {s_clk, s_css, s_mosi};
            pin_sync_reg <= pin_meta_reg;
            sclk_d_reg   <= sclk_s;
            css_d_reg    <= css_s;

            if (prog_cnt_reg != '0) begin
                prog_cnt_reg <= prog_cnt_reg - PCW'(1);
                if (prog_cnt_reg == PCW'(1))
                    wip_reg <= 1'b0;
            end
            if (erasing_reg) begin
                erase_ptr_reg <= erase_ptr_reg + ADDR_W'(1);
                if (&erase_ptr_reg) begin
                    erasing_reg <= 1'b0;
                    wip_reg     <= 1'b0;
                end
            end

            if (css_rise && in_frame) begin
                state_reg <= ST_IDLE;
                s_miso_oe <= 1'b0;
                s_miso    <= 1'b0;
                if (prog_reg) begin
                    wel_reg <= 1'b0;
                    if (pp_any_now) begin
                        wip_reg      <= 1'b1;
                        prog_cnt_reg <= PCW'(PROG_CYCLES);
                    end
                end else if (exact_now) begin
                    case (act_now)
                        ACT_WREN: wel_reg <= 1'b1;
                        ACT_WRDI: wel_reg <= 1'b0;
                        ACT_CE: begin
                            wel_reg       <= 1'b0;
                            wip_reg       <= 1'b1;
                            erasing_reg   <= 1'b1;
                            erase_ptr_reg <= '0;
                        end
                        default: ;
                    endcase
                end
            end else if (css_fall && !in_frame) begin
                state_reg     <= ST_CMD;
                bit_cnt_reg   <= 3'd0;
                act_reg       <= ACT_NONE;
                cmd_exact_reg <= 1'b0;
                prog_reg      <= 1'b0;
                pp_bytes_reg  <= 1'b0;
                addr_cnt_reg  <= 2'd0;
            end else if (in_frame) begin
                if (clk_rise) begin
                    bit_cnt_reg   <= bit_cnt_reg + 3'd1;
                    sr_reg        <= rx_byte[6:0];
                    cmd_exact_reg <= 1'b0;
                end
                if (byte_done) begin
                    case (state_reg)
                        ST_CMD: begin
                            state_reg     <= state_dec;
                            act_reg       <= act_dec;
                            prog_reg      <= prog_dec;
                            cmd_exact_reg <= 1'b1;
                        end
                        ST_ADDR: begin
                            addr_reg     <= ADDR_W'({addr_reg, rx_byte});
                            addr_cnt_reg <= addr_cnt_reg + 2'd1;
                            if (addr_cnt_reg == 2'd2)
                                state_reg <= prog_reg ? ST_PP_DATA : ST_RD_DATA;
                        end
                        ST_RD_DATA: addr_reg <= addr_reg + ADDR_W'(1);
                        ST_PP_DATA: begin
                            pp_bytes_reg <= 1'b1;
                            addr_reg     <= {addr_reg[ADDR_W-1:PAGE_W], page_off_inc};
                        end
                        default: ;
                    endcase
                end
                // Bit 7 of a new byte goes out on the falling edge that starts the byte.
                if (clk_fall && (state_reg == ST_RD_DATA || state_reg == ST_RDSR)) begin
                    s_miso_oe <= 1'b1;
                    if (bit_cnt_reg == 3'd0) begin
                        s_miso <= tx_byte[7];
                        tx_reg <= tx_byte[6:0];
                    end else begin
                        s_miso <= tx_reg[6];
                        tx_reg <= {tx_reg[5:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule
